// File: rtl/instruction_sequencer_if.sv
// Bus between the phase sequencer and its surroundings (decoder, memory, halt terminator).
// The step input exists only when SINGLE_STEP_EN is defined.
interface instruction_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    // Handshake: mem_wait=1 acts as "not ready" and holds FETCH, and the sequencer
    // leaves FETCH on the first edge that sees mem_wait=0. halted is a level that
    // wins over every other transition at the edge where it is seen high.
    logic                halted;
    logic                mem_wait;
    logic [1:0]          exec_cycles;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
`ifdef SINGLE_STEP_EN
    logic                step;
`endif
    logic                fetch;
    logic                decode;
    logic                execute;
    logic                instruction_end;
    logic [PC_WIDTH-1:0] pc;
    logic                pc_overflow;

    modport master (
`ifdef SINGLE_STEP_EN
        input  step,
`endif
        input  halted, mem_wait, exec_cycles, branch_taken, branch_target,
        output fetch, decode, execute, instruction_end, pc, pc_overflow
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        output step,
`endif
        output halted, mem_wait, exec_cycles, branch_taken, branch_target,
        input  fetch, decode, execute, instruction_end, pc, pc_overflow
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Phase sequencer and program counter: FETCH -> DECODE -> EXECUTE(1..4), frozen by halted.
// Optional feature macro: SINGLE_STEP_EN (adds step input and PAUSE state).
module instruction_sequencer #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instruction_sequencer_if.master bus,
    output logic [2:0]              o_dbg_state
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_STOPPED = 3'd4;
`ifdef SINGLE_STEP_EN
    localparam logic [2:0] S_PAUSE   = 3'd5;
`endif

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [1:0]          r_cnt;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_pc_overflow;
    logic                w_last_exec;
    logic                w_pc_update;

    assign w_last_exec = (r_state == S_EXECUTE) && (r_cnt == 2'd0);
    // An instruction aborted by halted must not retire its pc update.
    assign w_pc_update = w_last_exec && !bus.halted;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    w_state_next = S_FETCH;
            S_FETCH:   if (!bus.mem_wait) w_state_next = S_DECODE;
            S_DECODE:  w_state_next = S_EXECUTE;
            S_EXECUTE: begin
                if (r_cnt == 2'd0) begin
`ifdef SINGLE_STEP_EN
                    w_state_next = S_PAUSE;
`else
                    w_state_next = S_FETCH;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE:   if (bus.step) w_state_next = S_FETCH;
`endif
            S_STOPPED: w_state_next = S_STOPPED;
            default:   w_state_next = S_IDLE;
        endcase
        if (bus.halted && (r_state != S_STOPPED)) w_state_next = S_STOPPED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_pc          <= RESET_PC;
            r_pc_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_cnt <= bus.exec_cycles;
            end else if ((r_state == S_EXECUTE) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_pc_update) begin
                if (bus.branch_taken) begin
                    r_pc <= bus.branch_target;
                end else begin
                    r_pc <= r_pc + 1'b1;
                    if (&r_pc) r_pc_overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.fetch           = (r_state == S_FETCH);
    assign bus.decode          = (r_state == S_DECODE);
    assign bus.execute         = (r_state == S_EXECUTE);
    assign bus.instruction_end = w_last_exec;
    assign bus.pc              = r_pc;
    assign bus.pc_overflow     = r_pc_overflow;
    assign o_dbg_state         = r_state;
endmodule
